// File: rtl/rom_sample_playback_ctrl.sv
// Plays the X/Y/Z sample tables out of a combinational ROM at a fixed tick rate,
// presenting each captured triple downstream over a valid/ready handshake.
module rom_sample_playback_ctrl #(
    parameter int DATA_WIDTH       = 16,
    parameter int ADDRESS_WIDTH    = 4,
    parameter int TICKS_PER_SAMPLE = 50000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop_en,
    output logic                     rom_ce,
    output logic                     rom_read_en,
    output logic [ADDRESS_WIDTH-1:0] rom_address,
    input  logic [DATA_WIDTH-1:0]    rom_data_x,
    input  logic [DATA_WIDTH-1:0]    rom_data_y,
    input  logic [DATA_WIDTH-1:0]    rom_data_z,
    output logic [DATA_WIDTH-1:0]    out_x,
    output logic [DATA_WIDTH-1:0]    out_y,
    output logic [DATA_WIDTH-1:0]    out_z,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done
);

    localparam int                     TICK_W    = $clog2(TICKS_PER_SAMPLE) + 1;
    localparam logic [TICK_W-1:0]        TICK_LAST = TICK_W'(TICKS_PER_SAMPLE - 1);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_LAST = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_TICK,
        S_READ,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [TICK_W-1:0]        r_tick;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]    r_x;
    logic [DATA_WIDTH-1:0]    r_y;
    logic [DATA_WIDTH-1:0]    r_z;

    logic w_tick_clr;
    logic w_addr_clr;
    logic w_addr_inc;
    logic w_capture;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // stop overrides every other transition once playback has begun
    always_comb begin
        w_state_next = r_state;
        w_tick_clr   = 1'b0;
        w_addr_clr   = 1'b0;
        w_addr_inc   = 1'b0;
        w_capture    = 1'b0;
        if ((r_state != S_IDLE) && stop) begin
            w_state_next = S_IDLE;
            w_addr_clr   = 1'b1;
            w_tick_clr   = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !stop) begin
                        w_state_next = S_WAIT_TICK;
                        w_tick_clr   = 1'b1;
                    end
                end
                S_WAIT_TICK: begin
                    if (r_tick == TICK_LAST) begin
                        w_state_next = S_READ;
                    end
                end
                S_READ: begin
                    w_state_next = S_PRESENT;
                    w_capture    = 1'b1;
                end
                S_PRESENT: begin
                    if (out_ready) begin
                        if (r_addr != ADDR_LAST) begin
                            w_state_next = S_WAIT_TICK;
                            w_addr_inc   = 1'b1;
                            w_tick_clr   = 1'b1;
                        end else if (loop_en) begin
                            w_state_next = S_WAIT_TICK;
                            w_addr_clr   = 1'b1;
                            w_tick_clr   = 1'b1;
                        end else begin
                            w_state_next = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    w_state_next = S_IDLE;
                    w_addr_clr   = 1'b1;
                end
                default: begin
                    w_state_next = S_IDLE;
                    w_addr_clr   = 1'b1;
                end
            endcase
        end
    end

    // the tick counter only advances while waiting for the next sample slot
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick <= '0;
        end else if (w_tick_clr) begin
            r_tick <= '0;
        end else if (r_state == S_WAIT_TICK) begin
            r_tick <= r_tick + TICK_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
        end else if (w_addr_clr) begin
            r_addr <= '0;
        end else if (w_addr_inc) begin
            r_addr <= r_addr + ADDRESS_WIDTH'(1);
        end
    end

    // ROM outputs are combinational, so they are valid during READ and captured at its end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
            r_z <= '0;
        end else if (w_capture) begin
            r_x <= rom_data_x;
            r_y <= rom_data_y;
            r_z <= rom_data_z;
        end
    end

    assign rom_ce      = (r_state == S_READ);
    assign rom_read_en = (r_state == S_READ);
    assign rom_address = r_addr;
    assign out_x       = r_x;
    assign out_y       = r_y;
    assign out_z       = r_z;
    assign out_valid   = (r_state == S_PRESENT);
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);

endmodule

// File: tb/tb_rom_sample_playback_ctrl.sv
// Bench for rom_sample_playback_ctrl: two instances (4 ticks and 1 tick per sample)
// share stimulus and are compared each cycle against a countdown-based reference model.
module tb_rom_sample_playback_ctrl;

    localparam int DW = 16;
    localparam int AW = 2;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst, start, stop, loop_en, out_ready;

    logic          ce   [2];
    logic          re   [2];
    logic [AW-1:0] addr [2];
    logic [DW-1:0] dx   [2];
    logic [DW-1:0] dy   [2];
    logic [DW-1:0] dz   [2];
    logic [DW-1:0] ox   [2];
    logic [DW-1:0] oy   [2];
    logic [DW-1:0] oz   [2];
    logic          vld  [2];
    logic          busy [2];
    logic          done [2];

    logic [DW-1:0] rom_x [DEPTH];
    logic [DW-1:0] rom_y [DEPTH];
    logic [DW-1:0] rom_z [DEPTH];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_rom
        assign dx[g] = rom_x[addr[g]];
        assign dy[g] = rom_y[addr[g]];
        assign dz[g] = rom_z[addr[g]];
    end

    rom_sample_playback_ctrl #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .TICKS_PER_SAMPLE(4)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
        .rom_ce(ce[0]), .rom_read_en(re[0]), .rom_address(addr[0]),
        .rom_data_x(dx[0]), .rom_data_y(dy[0]), .rom_data_z(dz[0]),
        .out_x(ox[0]), .out_y(oy[0]), .out_z(oz[0]), .out_valid(vld[0]),
        .out_ready(out_ready), .busy(busy[0]), .done(done[0])
    );

    rom_sample_playback_ctrl #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .TICKS_PER_SAMPLE(1)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
        .rom_ce(ce[1]), .rom_read_en(re[1]), .rom_address(addr[1]),
        .rom_data_x(dx[1]), .rom_data_y(dy[1]), .rom_data_z(dz[1]),
        .out_x(ox[1]), .out_y(oy[1]), .out_z(oz[1]), .out_valid(vld[1]),
        .out_ready(out_ready), .busy(busy[1]), .done(done[1])
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    endtask

    function automatic int tps(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    // Reference model: a sample slot is "left" cycles away, then one read cycle,
    // then a presented sample until accepted, then (end of a single pass) a done cycle.
    bit            mdl_ok = 1'b0;
    logic          m_act [2];
    int            m_left[2];
    logic          m_rd  [2];
    logic          m_vld [2];
    logic          m_dn  [2];
    int            m_idx [2];
    logic [DW-1:0] m_x   [2];
    logic [DW-1:0] m_y   [2];
    logic [DW-1:0] m_z   [2];

    int cyc = 0;
    int st_edge = 0;
    int hs_t_a[$];
    int hs_a_a[$];
    int hs_x_a[$];
    int hs_t_b[$];
    int n_done[2];
    int n_read[2];
    int n_idle[2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                if (vld[k] && out_ready) begin
                    if (k == 0) begin
                        hs_t_a.push_back(cyc);
                        hs_a_a.push_back(int'(addr[0]));
                        hs_x_a.push_back(int'(ox[0]));
                    end else begin
                        hs_t_b.push_back(cyc);
                    end
                end
                if (done[k]) n_done[k]++;
                if (re[k]) n_read[k]++;
                if (!busy[k]) n_idle[k]++;
                if (k == 0 && start && !stop && !busy[0]) st_edge = cyc;
            end
            if (rst) begin
                m_act[k] = 0; m_left[k] = 0; m_rd[k] = 0; m_vld[k] = 0; m_dn[k] = 0;
                m_idx[k] = 0; m_x[k] = '0; m_y[k] = '0; m_z[k] = '0;
            end else if (m_act[k] && stop) begin
                m_act[k] = 0; m_left[k] = 0; m_rd[k] = 0; m_vld[k] = 0; m_dn[k] = 0;
                m_idx[k] = 0;
            end else if (!m_act[k]) begin
                if (start && !stop) begin
                    m_act[k] = 1; m_left[k] = tps(k);
                end
            end else if (m_left[k] > 0) begin
                m_left[k]--;
                if (m_left[k] == 0) m_rd[k] = 1;
            end else if (m_rd[k]) begin
                m_rd[k] = 0; m_vld[k] = 1;
                m_x[k] = rom_x[m_idx[k]]; m_y[k] = rom_y[m_idx[k]]; m_z[k] = rom_z[m_idx[k]];
            end else if (m_vld[k]) begin
                if (out_ready) begin
                    m_vld[k] = 0;
                    if (m_idx[k] < DEPTH - 1) begin
                        m_idx[k]++; m_left[k] = tps(k);
                    end else if (loop_en) begin
                        m_idx[k] = 0; m_left[k] = tps(k);
                    end else begin
                        m_dn[k] = 1;
                    end
                end
            end else if (m_dn[k]) begin
                m_dn[k] = 0; m_act[k] = 0; m_idx[k] = 0;
            end
        end
        if (rst) mdl_ok = 1'b1;
        cyc++;
    end

    always @(negedge clk) begin
        if (mdl_ok) begin
            for (int k = 0; k < 2; k++) begin
                chk((k == 0) ? "A.ctl" : "B.ctl",
                    64'({busy[k], ce[k], re[k], vld[k], done[k], addr[k]}),
                    64'({m_act[k], m_rd[k], m_rd[k], m_vld[k], m_dn[k], 2'(m_idx[k])}));
                chk((k == 0) ? "A.data" : "B.data",
                    64'({ox[k], oy[k], oz[k]}), 64'({m_x[k], m_y[k], m_z[k]}));
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int i;
        for (i = 0; i < 300; i++) begin
            if (!busy[0] && !busy[1]) break;
            tick(1);
        end
        chk(tag, 64'(i < 300), 64'(1));
    endtask

    task automatic fill_rom();
        for (int i = 0; i < DEPTH; i++) begin
            rom_x[i] = DW'($urandom);
            rom_y[i] = DW'($urandom);
            rom_z[i] = DW'($urandom);
        end
    endtask

    initial begin
        int b, b1, d0, d1, r0, r1, i0, i;
        rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            n_done[k] = 0; n_read[k] = 0; n_idle[k] = 0;
        end
        fill_rom();
        tick(3);
        rst = 1'b0;
        chk("rst.busy", 64'(busy[0]), 64'(0));
        chk("rst.out_x", 64'(ox[0]), 64'(0));

        // single pass with ascending X values
        for (int j = 0; j < DEPTH; j++) rom_x[j] = DW'(j + 1);
        b = hs_t_a.size(); b1 = hs_t_b.size();
        d0 = n_done[0]; d1 = n_done[1]; r0 = n_read[0]; r1 = n_read[1];
        loop_en = 1'b0; out_ready = 1'b1;
        pulse_start();
        wait_idle("sp.finish");
        tick(2);
        chk("sp.n_xfer", 64'(hs_t_a.size() - b), 64'(4));
        if (hs_t_a.size() - b == 4) begin
            for (int j = 0; j < 4; j++) begin
                chk("sp.data", 64'(hs_x_a[b + j]), 64'(j + 1));
                chk("sp.gap", 64'(hs_t_a[b + j] - ((j == 0) ? st_edge : hs_t_a[b + j - 1])), 64'(6));
            end
        end
        chk("sp.done", 64'(n_done[0] - d0), 64'(1));
        chk("sp.reads", 64'(n_read[0] - r0), 64'(4));
        chk("sp1.n_xfer", 64'(hs_t_b.size() - b1), 64'(4));
        if (hs_t_b.size() - b1 == 4) begin
            for (int j = 1; j < 4; j++)
                chk("sp1.gap", 64'(hs_t_b[b1 + j] - hs_t_b[b1 + j - 1]), 64'(3));
            chk("sp1.first", 64'(hs_t_b[b1] - st_edge), 64'(3));
        end
        chk("sp1.done", 64'(n_done[1] - d1), 64'(1));
        chk("sp1.reads", 64'(n_read[1] - r1), 64'(4));

        // backpressure on the first sample
        fill_rom();
        out_ready = 1'b0;
        pulse_start();
        for (i = 0; i < 50; i++) begin
            if (vld[0]) break;
            tick(1);
        end
        chk("bp.valid_up", 64'(vld[0]), 64'(1));
        r0 = n_read[0];
        for (int j = 0; j < 10; j++) begin
            tick(1);
            chk("bp.valid", 64'(vld[0]), 64'(1));
            chk("bp.x", 64'(ox[0]), 64'(rom_x[0]));
            chk("bp.addr", 64'(addr[0]), 64'(0));
        end
        chk("bp.reads", 64'(n_read[0] - r0), 64'(0));
        b = hs_t_a.size();
        out_ready = 1'b1;
        tick(1);
        chk("bp.xfer", 64'(hs_t_a.size() - b), 64'(1));
        chk("bp.addr_next", 64'(addr[0]), 64'(1));
        wait_idle("bp.finish");

        // looping playback
        loop_en = 1'b1;
        b = hs_t_a.size(); d0 = n_done[0];
        pulse_start();
        i0 = n_idle[0];
        for (i = 0; i < 200; i++) begin
            if (hs_t_a.size() - b >= 6) break;
            tick(1);
        end
        chk("loop.n_xfer", 64'(hs_t_a.size() - b >= 6), 64'(1));
        if (hs_t_a.size() - b >= 6)
            for (int j = 0; j < 6; j++) chk("loop.addr", 64'(hs_a_a[b + j]), 64'(j % 4));
        chk("loop.done", 64'(n_done[0] - d0), 64'(0));
        chk("loop.busy", 64'(n_idle[0] - i0), 64'(0));
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        chk("loop.stop_busy", 64'(busy[0]), 64'(0));
        loop_en = 1'b0;

        // stop in WAIT_TICK after the second sample, then restart
        fill_rom();
        b = hs_t_a.size();
        pulse_start();
        for (i = 0; i < 100; i++) begin
            if (hs_t_a.size() - b >= 2) break;
            tick(1);
        end
        tick(1);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        chk("stop.busy", 64'(busy[0]), 64'(0));
        chk("stop.valid", 64'(vld[0]), 64'(0));
        chk("stop.x_hold", 64'(ox[0]), 64'(rom_x[1]));
        chk("stop.addr", 64'(addr[0]), 64'(0));
        b = hs_t_a.size();
        pulse_start();
        tick(2);
        pulse_start();
        for (i = 0; i < 100; i++) begin
            if (hs_t_a.size() - b >= 1) break;
            tick(1);
        end
        chk("restart.addr", 64'((hs_t_a.size() > b) ? hs_a_a[b] : -1), 64'(0));
        wait_idle("restart.finish");

        // start and stop together while idle
        start = 1'b1; stop = 1'b1;
        tick(1);
        start = 1'b0; stop = 1'b0;
        chk("ss.busy_a", 64'(busy[0]), 64'(0));
        chk("ss.busy_b", 64'(busy[1]), 64'(0));

        // reset while a sample is being presented
        out_ready = 1'b0;
        d0 = n_done[0];
        pulse_start();
        for (i = 0; i < 50; i++) begin
            if (vld[0]) break;
            tick(1);
        end
        out_ready = 1'b1;
        rst = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick(1);
            chk("rstp.busy", 64'(busy[0]), 64'(0));
            chk("rstp.valid", 64'(vld[0]), 64'(0));
            chk("rstp.x", 64'(ox[0]), 64'(0));
            chk("rstp.rd", 64'({ce[0], re[0], addr[0], done[0]}), 64'(0));
        end
        rst = 1'b0;
        tick(2);
        chk("rstp.no_done", 64'(n_done[0] - d0), 64'(0));

        // randomized traffic including start-while-busy, stop and occasional reset
        fill_rom();
        for (int j = 0; j < 3000; j++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            start     = ($urandom_range(0, 19) == 0);
            stop      = ($urandom_range(0, 149) == 0);
            loop_en   = ($urandom_range(0, 1) == 1);
            rst       = ($urandom_range(0, 799) == 0);
            if ($urandom_range(0, 499) == 0) fill_rom();
            tick(1);
        end
        rst = 1'b0; start = 1'b0; stop = 1'b0;
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rom_sample_playback_ctrl.md
# rom_sample_playback_ctrl

Sequencer that plays back the stored accelerometer X/Y/Z sample tables at a programmable sample rate. Drives the chip-enable, read-enable and address of the sample ROM, captures each X/Y/Z triple into output registers, and hands it downstream (display/UART formatter) over a valid/ready handshake. Supports single-pass or looping playback with start/stop control.

## Interface
- DATA_WIDTH, 16, width of each axis sample
- ADDRESS_WIDTH, 4, ROM address width; table depth 2**ADDRESS_WIDTH
- TICKS_PER_SAMPLE, 50000, clk cycles spent in WAIT_TICK per sample; legal range >= 1
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin playback from address 0; sampled in IDLE only
- stop  in  1  abort playback; priority over start
- loop_en  in  1  1 = wrap to address 0 after last entry; 0 = finish
- rom_ce  out  1  ROM chip enable
- rom_read_en  out  1  ROM read enable
- rom_address  out  ADDRESS_WIDTH  ROM address; also current sample index
- rom_data_x / rom_data_y / rom_data_z  in  DATA_WIDTH each  combinational ROM outputs
- out_x / out_y / out_z  out  DATA_WIDTH each  registered sample
- out_valid  out  1  sample available
- out_ready  in  1  downstream accepts sample
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at end of non-looping pass

## Operation
- States: IDLE, WAIT_TICK, READ, PRESENT, DONE.
- IDLE: rom_ce = rom_read_en = 0, rom_address = 0. When start = 1 and stop = 0, go to WAIT_TICK and clear the tick counter.
- WAIT_TICK: tick counter increments every cycle. When the counter reaches TICKS_PER_SAMPLE-1, go to READ.
- READ: exactly one cycle with rom_ce = rom_read_en = 1. The ROM is combinational, so rom_data_* are registered into out_* at the end of this cycle. Next state is PRESENT and out_valid becomes 1.
- PRESENT: rom_ce = rom_read_en = 0. out_valid and out_* hold stable until out_ready = 1, which completes the handshake. On the handshake cycle:
  - If rom_address is not the last entry: increment the address and go to WAIT_TICK with the counter cleared.
  - If rom_address is the last entry and loop_en = 1: set the address to 0 and go to WAIT_TICK.
  - If rom_address is the last entry and loop_en = 0: go to DONE.
  - loop_en is sampled on the handshake cycle only.
- DONE: done = 1 for one cycle, then go to IDLE.
- rom_ce and rom_read_en are asserted only in READ. They are never high in any other state.
- stop = 1 in any non-IDLE state:
  - next state is IDLE, the address is cleared and out_valid drops.
  - out_* keep their last values.
  - done is not pulsed.
- start outside IDLE is ignored. If start and stop are asserted together in IDLE, the block stays in IDLE.
- Tick counter width is clog2(TICKS_PER_SAMPLE)+1. The counter does not run outside WAIT_TICK.
- The address wraps only through the loop_en path. It never increments past 2**ADDRESS_WIDTH-1.

## Timing
- Reset values: state IDLE; rom_ce 0, rom_read_en 0, rom_address 0; out_x/out_y/out_z 0; out_valid 0; busy 0; done 0.
- start sampled at edge N: busy = 1 from cycle N+1. WAIT_TICK occupies cycles N+1 .. N+TICKS_PER_SAMPLE. READ is at cycle N+TICKS_PER_SAMPLE+1. out_valid = 1 from cycle N+TICKS_PER_SAMPLE+2.
- With out_ready held high, the sample period is TICKS_PER_SAMPLE+2 cycles. Every cycle of backpressure in PRESENT adds one cycle.
- Handshake: transfer occurs on an edge where out_valid and out_ready are both 1. out_valid drops on the following cycle. out_* change only on the edge that ends READ.
- Last handshake with loop_en = 0 at edge M: done = 1 in cycle M+1, busy = 0 from cycle M+2.
- stop at edge S: IDLE from cycle S+1, with busy = 0 and out_valid = 0.
- rst mid-operation overrides everything at the next edge, including a pending handshake and a pending done.

## Test plan
- Reset check: assert rst for 3 cycles in the middle of PRESENT -> all outputs at their reset values, state IDLE, no done pulse.
- Single pass, ADDRESS_WIDTH = 2, TICKS_PER_SAMPLE = 4, out_ready = 1, ROM x = {0x0001, 0x0002, 0x0003, 0x0004} -> 4 transfers carrying 1, 2, 3, 4, spaced 6 cycles apart; the first out_valid appears 6 cycles after the start edge; one done pulse; rom_read_en high for exactly 4 single cycles.
- Backpressure: hold out_ready = 0 for 10 cycles in PRESENT -> out_valid and out_x/y/z stay stable; rom_read_en stays 0; the address does not change; the transfer completes when out_ready rises.
- Loop: loop_en = 1, depth 4 -> the address sequence is 0, 1, 2, 3, 0, 1; done never asserts; busy stays high.
- Stop mid-WAIT_TICK after sample 2 -> IDLE the next cycle; out_x still holds sample 2's value; a new start restarts at address 0.
- Edge cases:
  - start and stop together in IDLE -> stays in IDLE.
  - start pulsed while busy -> no effect on the sequence.
  - TICKS_PER_SAMPLE = 1 -> sample period is 3 cycles.
